id_ex_pipeline_register: RTL

//  Decode->Execute pipeline register of the 5-stage RISC-V core; feeds Instr_E/PC_E/operands to the Execute control and ALU.

---
 rtl/id_ex_pipeline_register.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipeline_register.sv
// Decode->Execute pipeline register with load-use hazard detection, flush/stall
// handling and a saturating counter of inserted bubbles.
module id_ex_pipeline_register #(
    parameter int          XLEN  = 32,
    parameter logic [31:0] NOP   = 32'h00000013,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instr_D,
    input  logic [XLEN-1:0]  PC_D,
    input  logic             Valid_D,
    input  logic [XLEN-1:0]  RS1Data_D,
    input  logic [XLEN-1:0]  RS2Data_D,
    input  logic [XLEN-1:0]  Imm_D,
    input  logic             RegWEn_D,
    input  logic             MemRW_D,
    input  logic [1:0]       WBSel_D,
    input  logic             Flush_E,
    input  logic             ExtStall_i,
    output logic [31:0]      Instr_E,
    output logic [XLEN-1:0]  PC_E,
    output logic [XLEN-1:0]  RS1Data_E,
    output logic [XLEN-1:0]  RS2Data_E,
    output logic [XLEN-1:0]  Imm_E,
    output logic             RegWEn_E,
    output logic             MemRW_E,
    output logic [1:0]       WBSel_E,
    output logic             Valid_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            reg_wen;
        logic            mem_rw;
        logic [1:0]      wb_sel;
        logic            valid;
    } ex_stage_t;

    typedef enum logic [1:0] {
        UPD_CAPTURE,
        UPD_HOLD,
        UPD_BUBBLE
    } upd_e;

    // The reset state and the bubble are the same harmless addi x0,x0,0.
    localparam ex_stage_t BUBBLE = '{
        instr:    NOP,
        pc:       '0,
        rs1_data: '0,
        rs2_data: '0,
        imm:      '0,
        reg_wen:  1'b0,
        mem_rw:   1'b0,
        wb_sel:   2'b00,
        valid:    1'b0
    };

    ex_stage_t        ex_q;
    ex_stage_t        ex_d;
    upd_e             upd;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic [6:0] opcode_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_e;
    logic       load_e;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;

    assign opcode_d = Instr_D[6:0];
    assign rs1_d    = Instr_D[19:15];
    assign rs2_d    = Instr_D[24:20];
    assign rd_e     = ex_q.instr[11:7];

    // A load writing x0 produces nothing a consumer could wait for.
    assign load_e  = ex_q.valid && (ex_q.instr[6:0] == OP_LOAD) && (rd_e != 5'd0);
    assign use_rs1 = Valid_D && !(opcode_d inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign use_rs2 = Valid_D && (opcode_d inside {OP_OP, OP_STORE, OP_BRANCH});
    assign hazard  = load_e && ((use_rs1 && (rs1_d == rd_e)) || (use_rs2 && (rs2_d == rd_e)));

    // A flush discards the younger instructions anyway, so it never asks them to wait.
    assign Stall_F = !Flush_E && (ExtStall_i || hazard);
    assign Stall_D = Stall_F;

    assign ex_d = '{
        instr:    Instr_D,
        pc:       PC_D,
        rs1_data: RS1Data_D,
        rs2_data: RS2Data_D,
        imm:      Imm_D,
        reg_wen:  RegWEn_D,
        mem_rw:   MemRW_D,
        wb_sel:   WBSel_D,
        valid:    Valid_D
    };

    always_comb begin
        // NOTE: default assignment first so no path leaves upd unassigned (no latch).
        upd = UPD_CAPTURE;
        if (Flush_E) begin
            upd = UPD_BUBBLE;
        end else if (ExtStall_i) begin
            upd = UPD_HOLD;
        end else if (hazard) begin
            upd = UPD_BUBBLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= BUBBLE;
            bubble_cnt_q <= '0;
        end else begin
            case (upd)
                UPD_BUBBLE:  ex_q <= BUBBLE;
                UPD_CAPTURE: ex_q <= ex_d;
                default:     ex_q <= ex_q;
            endcase
            if ((upd == UPD_BUBBLE) && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end
    end

    assign Instr_E   = ex_q.instr;
    assign PC_E      = ex_q.pc;
    assign RS1Data_E = ex_q.rs1_data;
    assign RS2Data_E = ex_q.rs2_data;
    assign Imm_E     = ex_q.imm;
    assign RegWEn_E  = ex_q.reg_wen;
    assign MemRW_E   = ex_q.mem_rw;
    assign WBSel_E   = ex_q.wb_sel;
    assign Valid_E   = ex_q.valid;
    assign BubbleCnt = bubble_cnt_q;

endmodule
